pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_if.sv | 29 ++
 rtl/pc_unit.sv | 121 ++++++++++++
 tb/tb_pc_unit.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_if.sv
// Fetch/redirect bus between the control path and the PC unit.
interface pc_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] br_pc;
  logic [XLEN-1:0] rs1_val;
  logic            ZERO;
  logic            Branch;
  logic            Jump;
  logic            Jalr;
  logic            trap;
  logic            stall;
  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic [XLEN-1:0] link_addr;
  logic            redirect;
  logic            misalign_err;

  modport master (
    output imm, br_pc, rs1_val, ZERO, Branch, Jump, Jalr, trap, stall,
    input  pc, pc_valid, link_addr, redirect, misalign_err
  );

  modport slave (
    input  imm, br_pc, rs1_val, ZERO, Branch, Jump, Jalr, trap, stall,
    output pc, pc_valid, link_addr, redirect, misalign_err
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter with branch/jump/jalr/trap redirect and stall-deferred redirects.
// Optional macro PC_MISALIGN_CHK_EN: misaligned targets trap when ADDR_STEP = 4.
module pc_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     ADDR_STEP = 1,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0010)
) (
  input logic clk,
  input logic rst,
  pc_if.slave bus
);

  localparam logic [XLEN-1:0] STEP      = XLEN'(ADDR_STEP);
  localparam logic [XLEN-1:0] JALR_MASK = (ADDR_STEP == 4) ? ~XLEN'(1) : '1;
`ifdef PC_MISALIGN_CHK_EN
  localparam bit CHK_EN = (ADDR_STEP == 4);
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

  state_t          state, state_nx;
  logic [XLEN-1:0] pc_q, pc_nx;
  logic [XLEN-1:0] pend_tgt, pend_tgt_nx;
  logic            pend_trap, pend_trap_nx;
  logic            redirect_q, redirect_nx;
  logic            mis_q, mis_nx;
  logic            valid_q, valid_nx;
  logic            taken, req, mis_req, mis_pend;
  logic [XLEN-1:0] req_tgt;

  // Request decode in priority order: trap > Jalr > Jump > taken branch.
  always_comb begin
    taken = bus.ZERO & bus.Branch;
    req   = bus.trap | bus.Jalr | bus.Jump | taken;
    if (bus.trap)      req_tgt = TRAP_VEC;
    else if (bus.Jalr) req_tgt = (bus.rs1_val + bus.imm) & JALR_MASK;
    else               req_tgt = bus.br_pc + bus.imm;
    mis_req  = CHK_EN && !bus.trap && (req_tgt[1:0] != 2'b00);
    mis_pend = CHK_EN && !pend_trap && (pend_tgt[1:0] != 2'b00);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BOOT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    pc_nx        = pc_q;
    pend_tgt_nx  = pend_tgt;
    pend_trap_nx = pend_trap;
    redirect_nx  = 1'b0;
    mis_nx       = 1'b0;
    case (state)
      BOOT: state_nx = RUN;
      RUN: begin
        if (bus.stall) begin
          if (req) begin
            pend_tgt_nx  = req_tgt;
            pend_trap_nx = bus.trap;
            state_nx     = PEND;
          end
        end else if (req) begin
          redirect_nx = 1'b1;
          mis_nx      = mis_req;
          pc_nx       = mis_req ? TRAP_VEC : req_tgt;
        end else begin
          pc_nx = pc_q + STEP;
        end
      end
      PEND: begin
        // Oldest redirect wins while stalled; only a trap may replace it.
        if (bus.stall) begin
          if (bus.trap) begin
            pend_tgt_nx  = TRAP_VEC;
            pend_trap_nx = 1'b1;
          end
        end else begin
          redirect_nx = 1'b1;
          state_nx    = RUN;
          if (bus.trap) begin
            pc_nx = TRAP_VEC;
          end else begin
            mis_nx = mis_pend;
            pc_nx  = mis_pend ? TRAP_VEC : pend_tgt;
          end
        end
      end
      default: state_nx = BOOT;
    endcase
    valid_nx = (state_nx != BOOT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      pend_tgt   <= '0;
      pend_trap  <= 1'b0;
      redirect_q <= 1'b0;
      mis_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_nx;
      pend_tgt   <= pend_tgt_nx;
      pend_trap  <= pend_trap_nx;
      redirect_q <= redirect_nx;
      mis_q      <= mis_nx;
      valid_q    <= valid_nx;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.pc_valid     = valid_q;
  assign bus.redirect     = redirect_q;
  assign bus.misalign_err = mis_q;
  assign bus.link_addr    = bus.br_pc + STEP;

endmodule

// File: tb/tb_pc_unit.sv
// Randomised bench for pc_unit: word- and byte-addressed instances checked every cycle
// against a behavioural model, plus directed literal checks.
module tb_pc_unit;

`ifdef PC_MISALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    bit          boot;
    bit          pend;
    logic [31:0] pend_tgt;
    bit          pend_trap;
    logic [31:0] pc;
    bit          redirect;
    bit          mis;
  } mdl_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        z, brn, jp, jr, tr, st;
  logic [31:0] bp, im, r1;
  int          ncmp = 0;
  int          nbad = 0;
  bit          cmp_on = 1'b1;
  mdl_t        ma, mb;

  always #5 clk = ~clk;

  pc_if #(.XLEN(32)) ia ();
  pc_if #(.XLEN(32)) ib ();

  assign ia.ZERO = z;   assign ib.ZERO = z;
  assign ia.Branch = brn; assign ib.Branch = brn;
  assign ia.Jump = jp;  assign ib.Jump = jp;
  assign ia.Jalr = jr;  assign ib.Jalr = jr;
  assign ia.trap = tr;  assign ib.trap = tr;
  assign ia.stall = st; assign ib.stall = st;
  assign ia.br_pc = bp; assign ib.br_pc = bp;
  assign ia.imm = im;   assign ib.imm = im;
  assign ia.rs1_val = r1; assign ib.rs1_val = r1;

  pc_unit #(.XLEN(32), .ADDR_STEP(1), .RESET_PC(32'h0), .TRAP_VEC(32'h10))
    dut_a (.clk(clk), .rst(rst), .bus(ia));
  pc_unit #(.XLEN(32), .ADDR_STEP(4), .RESET_PC(32'h100), .TRAP_VEC(32'h40))
    dut_b (.clk(clk), .rst(rst), .bus(ib));

  function automatic mdl_t mreset(input logic [31:0] rpc);
    mdl_t m;
    m.boot = 1'b1; m.pend = 1'b0; m.pend_tgt = '0; m.pend_trap = 1'b0;
    m.pc = rpc; m.redirect = 1'b0; m.mis = 1'b0;
    return m;
  endfunction

  // Next architectural state from the current inputs, per the redirect rules.
  function automatic mdl_t mstep(input mdl_t m, input int unsigned step, input logic [31:0] tvec);
    mdl_t        n;
    logic [31:0] tgt, ld;
    bit          any, ld_trap;
    bit          load;
    n = m;
    n.redirect = 1'b0;
    n.mis = 1'b0;
    load = 1'b0;
    ld = '0;
    ld_trap = 1'b0;
    any = tr || jr || jp || (z && brn);
    if (tr)      tgt = tvec;
    else if (jr) tgt = (step == 4) ? ((r1 + im) & 32'hFFFF_FFFE) : (r1 + im);
    else         tgt = bp + im;
    if (m.boot) begin
      n.boot = 1'b0;
    end else if (m.pend) begin
      if (st) begin
        if (tr) begin n.pend_tgt = tvec; n.pend_trap = 1'b1; end
      end else begin
        n.pend = 1'b0;
        load = 1'b1;
        ld = tr ? tvec : m.pend_tgt;
        ld_trap = tr || m.pend_trap;
      end
    end else if (st) begin
      if (any) begin n.pend = 1'b1; n.pend_tgt = tgt; n.pend_trap = tr; end
    end else if (any) begin
      load = 1'b1; ld = tgt; ld_trap = tr;
    end else begin
      n.pc = m.pc + step;
    end
    if (load) begin
      n.redirect = 1'b1;
      if (CHK && step == 4 && !ld_trap && ld[1:0] != 2'b00) begin
        n.pc = tvec; n.mis = 1'b1;
      end else begin
        n.pc = ld;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= mreset(32'h0);
      mb <= mreset(32'h100);
    end else begin
      ma <= mstep(ma, 1, 32'h10);
      mb <= mstep(mb, 4, 32'h40);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      check("a_pc", ia.pc, ma.pc);
      check("a_valid", 32'(ia.pc_valid), 32'(!ma.boot));
      check("a_redirect", 32'(ia.redirect), 32'(ma.redirect));
      check("a_misalign", 32'(ia.misalign_err), 32'(ma.mis));
      check("a_link", ia.link_addr, bp + 32'd1);
      check("b_pc", ib.pc, mb.pc);
      check("b_valid", 32'(ib.pc_valid), 32'(!mb.boot));
      check("b_redirect", 32'(ib.redirect), 32'(mb.redirect));
      check("b_misalign", 32'(ib.misalign_err), 32'(mb.mis));
      check("b_link", ib.link_addr, bp + 32'd4);
    end
  end

  task automatic set(input logic z_, b_, j_, jr_, t_, s_,
                     input logic [31:0] bp_, im_, r1_);
    z = z_; brn = b_; jp = j_; jr = jr_; tr = t_; st = s_;
    bp = bp_; im = im_; r1 = r1_;
  endtask

  task automatic idle();
    set(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_pc", ia.pc, 32'h0);
    check("rst_a_valid", 32'(ia.pc_valid), 32'h0);
    check("rst_b_pc", ib.pc, 32'h100);
    rst = 1'b0;
    #1 check("boot_a_valid", 32'(ia.pc_valid), 32'h0);
    tick(); check("run0_a_pc", ia.pc, 32'h0); check("run0_a_valid", 32'(ia.pc_valid), 32'h1);
    tick(); check("seq1_a_pc", ia.pc, 32'h1);
    tick(); check("seq2_a_pc", ia.pc, 32'h2);
    tick(); check("seq3_a_pc", ia.pc, 32'h3);

    set(1, 1, 0, 0, 0, 0, 32'h8, 32'hFFFF_FFFC, 32'h0); tick();
    check("br_taken_pc", ia.pc, 32'h4); check("br_taken_redir", 32'(ia.redirect), 32'h1);
    set(0, 1, 0, 0, 0, 0, 32'h8, 32'hFFFF_FFFC, 32'h0); tick();
    check("br_not_pc", ia.pc, 32'h5); check("br_not_redir", 32'(ia.redirect), 32'h0);

    set(0, 0, 1, 0, 0, 1, 32'h2, 32'h6, 32'h0); tick(); check("stall1_pc", ia.pc, 32'h5);
    set(1, 1, 0, 0, 0, 1, 32'h2, 32'd20, 32'h0); tick(); check("stall2_pc", ia.pc, 32'h5);
    set(0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0); tick(); check("stall3_pc", ia.pc, 32'h5);
    idle(); tick();
    check("pend_rel_pc", ia.pc, 32'h8); check("pend_rel_redir", 32'(ia.redirect), 32'h1);
    tick(); check("pend_after_pc", ia.pc, 32'h9);

    set(0, 0, 0, 1, 1, 0, 32'h0, 32'h2, 32'h100); tick();
    check("trap_jalr_a", ia.pc, 32'h10); check("trap_jalr_b", ib.pc, 32'h40);
    set(0, 0, 0, 1, 0, 1, 32'h0, 32'h0, 32'h200); tick();
    set(0, 0, 0, 1, 1, 1, 32'h0, 32'h0, 32'h200); tick();
    idle(); tick();
    check("pend_trap_a", ia.pc, 32'h10); check("pend_trap_b", ib.pc, 32'h40);
    set(0, 0, 1, 0, 0, 1, 32'h0, 32'h30, 32'h0); tick();
    set(0, 0, 0, 1, 1, 0, 32'h0, 32'h0, 32'h200); tick();
    check("rel_trap_a", ia.pc, 32'h10);

    set(0, 0, 0, 1, 0, 0, 32'h0, 32'h2, 32'h100); tick();
    check("jalr_a_pc", ia.pc, 32'h102);
`ifdef PC_MISALIGN_CHK_EN
    check("jalr_b_pc", ib.pc, 32'h40); check("jalr_b_mis", 32'(ib.misalign_err), 32'h1);
`else
    check("jalr_b_pc", ib.pc, 32'h102); check("jalr_b_mis", 32'(ib.misalign_err), 32'h0);
`endif

    set(0, 0, 1, 0, 0, 0, 32'h0, 32'hFFFF_FFFF, 32'h0); tick();
    check("wrap_max_pc", ia.pc, 32'hFFFF_FFFF);
    idle(); tick(); check("wrap_zero_pc", ia.pc, 32'h0);

    set(0, 0, 1, 0, 0, 1, 32'h0, 32'h50, 32'h0); tick();
    rst = 1'b1;
    #1;
    check("rst_pend_a_valid", 32'(ia.pc_valid), 32'h0);
    check("rst_pend_b_pc", ib.pc, 32'h100);
    idle(); tick();
    rst = 1'b0;
    tick(); check("rst_pend_boot_pc", ia.pc, 32'h0); check("rst_pend_redir", 32'(ia.redirect), 32'h0);
    tick(); check("rst_pend_seq_pc", ia.pc, 32'h1);

    for (int i = 0; i < 800; i++) begin
      z   = 1'($urandom_range(1));
      brn = ($urandom_range(2) == 0);
      jp  = ($urandom_range(5) == 0);
      jr  = ($urandom_range(5) == 0);
      tr  = ($urandom_range(15) == 0);
      st  = ($urandom_range(2) == 0);
      bp  = ($urandom_range(3) == 0) ? $urandom : 32'($urandom_range(255));
      im  = ($urandom_range(3) == 0) ? $urandom : 32'($urandom_range(63));
      r1  = ($urandom_range(3) == 0) ? $urandom : 32'($urandom_range(1023));
      if (rst)                              rst = 1'b0;
      else if ($urandom_range(99) == 0)     rst = 1'b1;
      tick();
    end

    rst = 1'b0;
    idle();
    tick();
    @(posedge clk);
    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
